ast_systolic_tile_sequencer: RTL and testbench

//  Parametrised sequencer for one SIZE x SIZE systolic MAC array. Replaces the fixed 2-phase controller.

---
 rtl/ast_sa_pkg.sv | 48 ++++
 rtl/ast_systolic_tile_sequencer_if.sv | 57 +++++
 rtl/ast_sa_skew_shifter.sv | 37 +++
 rtl/ast_systolic_tile_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_ast_systolic_tile_sequencer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/ast_sa_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ast_sa_pkg
// Description : Shared types and helpers for the systolic tile sequencer:
//               FSM state enum, MAC phase indices and width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package ast_sa_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MAC      = 3'd1,
        DONE     = 3'd2,
        CMP_ADD  = 3'd3,
        CMP_LD   = 3'd4,
        CMP_DONE = 3'd5
    } sa_state_e;

    // Phase 0 of every MAC step is the load/accumulate phase.
    localparam int PH_LOAD = 0;

    // The last phase of a MAC step is the multiply phase.
    function automatic int ph_mult(input int mac_phases);
        return mac_phases - 1;
    endfunction

    function automatic int ph_w(input int mac_phases);
        return (mac_phases > 1) ? $clog2(mac_phases) : 1;
    endfunction

    function automatic int dim_w(input int size);
        return $clog2(size) + 1;
    endfunction

    function automatic int cnt_w(input int size);
        return $clog2(size) + 2;
    endfunction

    // Row/column valid bit for a given step; limits beyond the array size
    // saturate to "always valid".
    function automatic logic sel_bit(input int unsigned step,
                                     input int unsigned lim,
                                     input int unsigned size);
        return (lim > size) || (step < lim);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ast_systolic_tile_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface   : ast_systolic_tile_sequencer_if
// Description : Host command / array control bundle of the tile sequencer.
//               master : sequencer side (takes commands, drives array strobes)
//               slave  : host/array side
//               SA_PERF_CNT_EN adds perf_cycles[31:0].
// Revision    : 1.0 - initial release
// ============================================================================
interface ast_systolic_tile_sequencer_if #(
    parameter int SIZE  = 16,
    parameter int CNT_W = $clog2(SIZE) + 2
);
    localparam int c_dim_w = $clog2(SIZE) + 1;

    logic               start;
    logic               compress;
    logic [CNT_W-1:0]   cfg_cycles;
    logic [c_dim_w-1:0] depth_A;
    logic [c_dim_w-1:0] width_B;

    logic               load_en;
    logic               acc_en;
    logic               mult_en;
    logic               next;
    logic [SIZE-1:0]    memsel_A;
    logic [SIZE-1:0]    memsel_B;
    logic               comp_add;
    logic               comp_en;
    logic               comp_ld;
    logic               busy;
    logic               done;
    logic               err;
`ifdef SA_PERF_CNT_EN
    logic [31:0]        perf_cycles;
`endif

    modport master (
        input  start, compress, cfg_cycles, depth_A, width_B,
`ifdef SA_PERF_CNT_EN
        output perf_cycles,
`endif
        output load_en, acc_en, mult_en, next, memsel_A, memsel_B,
        output comp_add, comp_en, comp_ld, busy, done, err
    );

    modport slave (
        output start, compress, cfg_cycles, depth_A, width_B,
`ifdef SA_PERF_CNT_EN
        input  perf_cycles,
`endif
        input  load_en, acc_en, mult_en, next, memsel_A, memsel_B,
        input  comp_add, comp_en, comp_ld, busy, done, err
    );

endinterface
`default_nettype wire

// File: rtl/ast_sa_skew_shifter.sv
`default_nettype none
// ============================================================================
// Module      : ast_sa_skew_shifter
// Description : SIZE-bit left shift register producing skewed row/column
//               selects. Clear has priority over shift.
//   clk, reset : clock, async active-high reset
//   i_clear    : synchronous clear to zero
//   i_shift_en : shift left by one, inserting i_bit_in at bit 0
//   o_q        : register contents
// Revision    : 1.0 - initial release
// ============================================================================
module ast_sa_skew_shifter #(
    parameter int SIZE = 16
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            i_clear,
    input  wire logic            i_shift_en,
    input  wire logic            i_bit_in,
    output logic [SIZE-1:0]      o_q
);
    logic [SIZE-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_clear) begin
            r_q <= '0;
        end else if (i_shift_en) begin
            r_q <= {r_q[SIZE-2:0], i_bit_in};
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/ast_systolic_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ast_systolic_tile_sequencer
// Description : Sequencer for one SIZE x SIZE systolic MAC array. Runs a
//               MAC sequence of cfg_cycles+1 steps of MAC_PHASES cycles each,
//               with skewed A/B selects, or a column compress sequence.
//               All outputs are registered.
//   clk, reset : clock, async active-high reset
//   sif        : command/strobe bundle (master modport)
//   Optional   : define SA_PERF_CNT_EN for the perf_cycles counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ast_systolic_tile_sequencer
    import ast_sa_pkg::*;
#(
    parameter int SIZE       = 16,
    parameter int MAC_PHASES = 2,
    parameter int CNT_W      = cnt_w(SIZE)
) (
    input wire logic clk,
    input wire logic reset,
    ast_systolic_tile_sequencer_if.master sif
);
    localparam int                c_dim_w   = dim_w(SIZE);
    localparam int                c_ph_w    = ph_w(MAC_PHASES);
    localparam logic [c_ph_w-1:0] c_ph_load = c_ph_w'(PH_LOAD);
    localparam logic [c_ph_w-1:0] c_ph_mult = c_ph_w'(ph_mult(MAC_PHASES));
    // Phase whose closing edge launches the multiply phase.
    localparam logic [c_ph_w-1:0] c_ph_pre  = c_ph_w'(MAC_PHASES - 2);

    sa_state_e          r_state;
    logic [c_ph_w-1:0]  r_phase;
    logic [CNT_W:0]     r_step;      // one bit wider so cfg+1 never wraps
    logic [CNT_W-1:0]   r_cfg;
    logic [c_dim_w-1:0] r_depth_a;
    logic [c_dim_w-1:0] r_width_b;
    logic [c_dim_w-1:0] r_count;
    logic r_load_en, r_acc_en, r_mult_en, r_next;
    logic r_comp_add, r_comp_en, r_comp_ld;
    logic r_busy, r_done, r_err;

    logic             w_cmd_any;
    logic             w_mac_accept;
    logic             w_shift;
    logic [CNT_W:0]   w_last_step;
    logic [SIZE-1:0]  w_memsel_a;
    logic [SIZE-1:0]  w_memsel_b;

    assign w_cmd_any    = sif.start || sif.compress;
    assign w_mac_accept = (r_state == IDLE) && !sif.compress && sif.start
                          && (sif.cfg_cycles != '0);
    // Selects advance on the edge that enters the multiply phase, using the
    // step index before it increments.
    assign w_shift      = (r_state == MAC) && (r_phase == c_ph_pre);
    assign w_last_step  = {1'b0, r_cfg} + {{CNT_W{1'b0}}, 1'b1};

    ast_sa_skew_shifter #(.SIZE(SIZE)) u_skew_a (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_mac_accept),
        .i_shift_en (w_shift),
        .i_bit_in   (sel_bit(32'(r_step), 32'(r_depth_a), SIZE)),
        .o_q        (w_memsel_a)
    );

    ast_sa_skew_shifter #(.SIZE(SIZE)) u_skew_b (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_mac_accept),
        .i_shift_en (w_shift),
        .i_bit_in   (sel_bit(32'(r_step), 32'(r_width_b), SIZE)),
        .o_q        (w_memsel_b)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_phase    <= '0;
            r_step     <= '0;
            r_cfg      <= '0;
            r_depth_a  <= '0;
            r_width_b  <= '0;
            r_count    <= '0;
            r_load_en  <= 1'b0;
            r_acc_en   <= 1'b0;
            r_mult_en  <= 1'b0;
            r_next     <= 1'b0;
            r_comp_add <= 1'b0;
            r_comp_en  <= 1'b0;
            r_comp_ld  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (sif.compress) begin
                        r_state    <= CMP_ADD;
                        r_busy     <= 1'b1;
                        r_comp_add <= 1'b1;
                        r_comp_en  <= 1'b1;
                        r_count    <= '0;
                        r_depth_a  <= sif.depth_A;
                        r_width_b  <= sif.width_B;
                    end else if (sif.start) begin
                        if (sif.cfg_cycles != '0) begin
                            r_state   <= MAC;
                            r_busy    <= 1'b1;
                            r_load_en <= 1'b1;
                            r_acc_en  <= 1'b1;
                            r_phase   <= c_ph_load;
                            r_step    <= '0;
                            r_cfg     <= sif.cfg_cycles;
                            r_depth_a <= sif.depth_A;
                            r_width_b <= sif.width_B;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                MAC: begin
                    if (w_cmd_any) r_err <= 1'b1;
                    if (r_phase == c_ph_mult) begin
                        r_mult_en <= 1'b0;
                        r_next    <= 1'b0;
                        if (r_step == w_last_step) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_phase   <= c_ph_load;
                            r_load_en <= 1'b1;
                            r_acc_en  <= 1'b1;
                        end
                    end else begin
                        r_load_en <= 1'b0;
                        r_acc_en  <= 1'b0;
                        r_phase   <= r_phase + 1'b1;
                        if (r_phase == c_ph_pre) begin
                            r_mult_en <= 1'b1;
                            r_next    <= 1'b1;
                            r_step    <= r_step + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                CMP_ADD: begin
                    if (w_cmd_any) r_err <= 1'b1;
                    // depth_A+1 add cycles: count runs 0..depth_A.
                    if (r_count == r_depth_a) begin
                        r_state    <= CMP_LD;
                        r_comp_add <= 1'b0;
                        r_comp_en  <= 1'b0;
                        r_comp_ld  <= 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                CMP_LD: begin
                    if (w_cmd_any) r_err <= 1'b1;
                    r_state   <= CMP_DONE;
                    r_comp_ld <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_count   <= '0;
                end
                CMP_DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef SA_PERF_CNT_EN
    // Counts every cycle from acceptance through the completion cycle.
    logic [31:0] r_perf;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf <= '0;
        end else if (w_mac_accept || ((r_state == IDLE) && sif.compress)) begin
            r_perf <= '0;
        end else if ((r_state != IDLE) && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end
    assign sif.perf_cycles = r_perf;
`endif

    assign sif.load_en  = r_load_en;
    assign sif.acc_en   = r_acc_en;
    assign sif.mult_en  = r_mult_en;
    assign sif.next     = r_next;
    assign sif.memsel_A = w_memsel_a;
    assign sif.memsel_B = w_memsel_b;
    assign sif.comp_add = r_comp_add;
    assign sif.comp_en  = r_comp_en;
    assign sif.comp_ld  = r_comp_ld;
    assign sif.busy     = r_busy;
    assign sif.done     = r_done;
    assign sif.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ast_systolic_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ast_systolic_tile_sequencer
// Description : Self-checking bench for ast_systolic_tile_sequencer. Two
//               instances (MAC_PHASES=2 and 3) share clock, reset and
//               configuration inputs; each has its own start/compress.
//               SA_PERF_CNT_EN enables the perf_cycles check.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ast_systolic_tile_sequencer;
    localparam int SIZE = 16;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] cfg   = '0;
    logic [4:0] depth = '0;
    logic [4:0] width = '0;
    logic       start2 = 1'b0, start3 = 1'b0, cmp2 = 1'b0, cmp3 = 1'b0;
    int         checks   = 0;
    int         failures = 0;
    logic [15:0] held_a [2];
    logic [15:0] held_b [2];

    always #5 clk = ~clk;

    ast_systolic_tile_sequencer_if #(.SIZE(SIZE)) i2 ();
    ast_systolic_tile_sequencer_if #(.SIZE(SIZE)) i3 ();

    assign i2.start = start2;  assign i2.compress = cmp2;
    assign i3.start = start3;  assign i3.compress = cmp3;
    assign i2.cfg_cycles = cfg;   assign i3.cfg_cycles = cfg;
    assign i2.depth_A    = depth; assign i3.depth_A    = depth;
    assign i2.width_B    = width; assign i3.width_B    = width;

    ast_systolic_tile_sequencer #(.SIZE(SIZE), .MAC_PHASES(2)) dut2 (
        .clk(clk), .reset(reset), .sif(i2));
    ast_systolic_tile_sequencer #(.SIZE(SIZE), .MAC_PHASES(3)) dut3 (
        .clk(clk), .reset(reset), .sif(i3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Strobe order: load acc mult next busy done err comp_add comp_en comp_ld
    function automatic logic [63:0] pk(input logic [9:0] s, input logic [15:0] a,
                                       input logic [15:0] b);
        return {22'd0, s, a, b};
    endfunction

    function automatic logic [63:0] obs(input int sel);
        if (sel == 3)
            return {22'd0, i3.load_en, i3.acc_en, i3.mult_en, i3.next, i3.busy,
                    i3.done, i3.err, i3.comp_add, i3.comp_en, i3.comp_ld,
                    i3.memsel_A, i3.memsel_B};
        return {22'd0, i2.load_en, i2.acc_en, i2.mult_en, i2.next, i2.busy,
                i2.done, i2.err, i2.comp_add, i2.comp_en, i2.comp_ld,
                i2.memsel_A, i2.memsel_B};
    endfunction

    // Skewed select after n shifts: the bit for step j sits at position n-1-j.
    function automatic logic [15:0] sel_model(input int n, input int lim);
        logic [63:0] v;
        v = '0;
        for (int j = 0; j < n; j++)
            if (lim > SIZE || j < lim) v[n-1-j] = 1'b1;
        return v[15:0];
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 3) start3 = v; else start2 = v;
    endtask

    task automatic set_cmp(input int sel, input logic v);
        if (sel == 3) cmp3 = v; else cmp2 = v;
    endtask

    // inj: -1 none, -2 random, otherwise cycle at which a busy start is sent.
    task automatic run_mac(input int sel, input int cfg_v, input int dep,
                           input int wid, input int inj_in);
        int P, n, p, k, ns, inj, idx;
        logic [15:0] ea, eb;
        logic e_ld, e_mu, e_er;
        P   = (sel == 3) ? 3 : 2;
        n   = (cfg_v + 1) * P;
        idx = (sel == 3) ? 1 : 0;
        inj = inj_in;
        if (inj == -2)
            inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 2)) : -1;
        cfg = 6'(cfg_v); depth = 5'(dep); width = 5'(wid);
        set_start(sel, 1'b1);
        tick();
        set_start(sel, 1'b0);
        cfg   = 6'($urandom_range(0, 63));
        depth = 5'($urandom_range(0, 31));
        width = 5'($urandom_range(0, 31));
        for (int t = 0; t < n; t++) begin
            p  = t % P;
            k  = t / P;
            ns = (p == P - 1) ? k + 1 : k;
            ea = sel_model(ns, dep);
            eb = sel_model(ns, wid);
            e_ld = (p == 0);
            e_mu = (p == P - 1);
            e_er = (inj >= 0) && (t == inj + 1);
            chk($sformatf("mac%0d_c%0d_t%0d", sel, cfg_v, t), obs(sel),
                pk({e_ld, e_ld, e_mu, e_mu, 1'b1, 1'b0, e_er, 3'b000}, ea, eb));
            set_start(sel, t == inj);
            tick();
        end
        set_start(sel, 1'b0);
        ea = sel_model(cfg_v + 1, dep);
        eb = sel_model(cfg_v + 1, wid);
        chk($sformatf("mac%0d_done", sel), obs(sel), pk(10'b0000010000, ea, eb));
        tick();
        chk($sformatf("mac%0d_idle", sel), obs(sel), pk(10'b0, ea, eb));
        held_a[idx] = ea;
        held_b[idx] = eb;
    endtask

    task automatic run_cmp(input int sel, input int dep, input logic with_start);
        int idx;
        idx = (sel == 3) ? 1 : 0;
        depth = 5'(dep);
        cfg   = 6'($urandom_range(1, 63));
        set_cmp(sel, 1'b1);
        set_start(sel, with_start);
        tick();
        set_cmp(sel, 1'b0);
        set_start(sel, 1'b0);
        depth = 5'($urandom_range(0, 31));
        for (int t = 0; t <= dep; t++) begin
            chk($sformatf("cmp%0d_add_t%0d", sel, t), obs(sel),
                pk(10'b0000100110, held_a[idx], held_b[idx]));
            tick();
        end
        chk($sformatf("cmp%0d_ld", sel), obs(sel),
            pk(10'b0000100001, held_a[idx], held_b[idx]));
        tick();
        chk($sformatf("cmp%0d_done", sel), obs(sel),
            pk(10'b0000010000, held_a[idx], held_b[idx]));
        tick();
        chk($sformatf("cmp%0d_idle", sel), obs(sel),
            pk(10'b0, held_a[idx], held_b[idx]));
    endtask

    initial begin
        held_a[0] = '0; held_a[1] = '0; held_b[0] = '0; held_b[1] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dut2", obs(2), 64'd0);
        chk("reset_dut3", obs(3), 64'd0);
        reset = 1'b0;
        tick();

        // Four-step MAC, two phases per step
        run_mac(2, 3, 2, 3, -1);
        chk("t1_memsel", 64'({i2.memsel_A, i2.memsel_B}), 64'({16'h000C, 16'h000E}));
`ifdef SA_PERF_CNT_EN
        chk("t1_perf", 64'(i2.perf_cycles), 64'd9);
`endif

        // Three-phase steps
        run_mac(3, 1, 5, 1, -1);

        // Compress wins over a simultaneous start
        run_cmp(2, 4, 1'b1);
        run_cmp(3, 0, 1'b0);

        // Start while busy, then start with zero cycles in IDLE
        run_mac(2, 4, 1, 4, 3);
        cfg = '0;
        set_start(3, 1'b1);
        tick();
        set_start(3, 1'b0);
        chk("zero_cfg_err", obs(3), pk(10'b0000001000, held_a[1], held_b[1]));
        tick();
        chk("zero_cfg_idle", obs(3), pk(10'b0, held_a[1], held_b[1]));

        // Saturating limits and the widest cycle count
        run_mac(2, 20, 18, 16, -1);
        run_mac(2, 63, 5, 31, -1);

        // Randomized runs
        for (int r = 0; r < 10; r++) begin
            if ($urandom_range(0, 3) == 0)
                run_cmp(($urandom_range(0, 1) == 1) ? 3 : 2,
                        int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
            else
                run_mac(($urandom_range(0, 1) == 1) ? 3 : 2,
                        int'($urandom_range(1, 12)), int'($urandom_range(0, 31)),
                        int'($urandom_range(0, 31)), -2);
        end

        // Reset asserted mid-MAC at step 2
        cfg = 6'd5; depth = 5'd3; width = 5'd3;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (4) tick();
        chk("pre_reset_step2", obs(2),
            pk(10'b1100100000, sel_model(2, 3), sel_model(2, 3)));
        reset = 1'b1;
        #1;
        chk("async_reset_dut2", obs(2), 64'd0);
        chk("async_reset_dut3", obs(3), 64'd0);
        reset = 1'b0;
        held_a[0] = '0; held_a[1] = '0; held_b[0] = '0; held_b[1] = '0;
        run_mac(2, 4, 1, 2, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
